// File: rtl/nn_seq_layer_if.sv
// nn_seq_layer bus bundle: run handshake, parameter write port and results.
// master drives requests, slave is the layer.
interface nn_seq_layer_if #(
  parameter int N_IN  = 4,
  parameter int N_HID = 3,
  parameter int IN_W  = 2,
  parameter int W_W   = 8,
  parameter int OUT_W = 12,
  parameter int AW    = $clog2(N_IN*N_HID+2*N_HID+1)
);
  logic                     start;
  logic [1:0]               act_mode;
  logic [N_IN*IN_W-1:0]     in_vec;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [W_W-1:0]           wr_data;
  logic                     busy;
  logic                     done;
  logic                     wr_err;
  logic [N_HID*OUT_W-1:0]   h_out;
  logic [OUT_W-1:0]         out_o;

  modport master (
    output start, act_mode, in_vec,
    output wr_en, wr_addr, wr_data,
    input  busy, done, wr_err, h_out, out_o
  );

  modport slave (
    input  start, act_mode, in_vec,
    input  wr_en, wr_addr, wr_data,
    output busy, done, wr_err, h_out, out_o
  );
endinterface

// File: rtl/nn_seq_layer.sv
// Two-layer fixed-point network, hidden and output neurons
// time-multiplexed over one multiply-accumulate unit.
module nn_seq_layer #(
  parameter int N_IN  = 4,
  parameter int N_HID = 3,
  parameter int IN_W  = 2,
  parameter int W_W   = 8,
  parameter int B_W   = 3,
  parameter int ACC_W = 20,
  parameter int OUT_W = 12
) (
  input logic          clk,
  input logic          rst_n,
  nn_seq_layer_if.slave bus
);
  localparam int FRAC   = W_W - 1;
  localparam int NPAR   = N_IN*N_HID + 2*N_HID + 1;
  localparam int AW     = $clog2(NPAR);
  localparam int V_BASE = N_IN*N_HID;
  localparam int B_BASE = V_BASE + N_HID;
  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int PW     = OUT_W + W_W;

  localparam longint BMAX  = ((longint'(1) << B_W) - 1) << FRAC;
  localparam longint MAX_H = longint'(N_IN) *
    ((longint'(1) << IN_W) - 1) * (longint'(1) << FRAC) + BMAX;
  localparam longint MAX_O = longint'(N_HID) *
    (longint'(1) << (OUT_W - 1)) + BMAX;
  localparam longint LIM   = longint'(1) << (ACC_W - 1);

  if (MAX_H >= LIM || MAX_O >= LIM) begin : g_acc_chk
    $error("nn_seq_layer: ACC_W too narrow for worst-case sums");
  end

  localparam logic signed [ACC_W-1:0] L_MAX  = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] L_MIN  = ~L_MAX;
  localparam logic signed [ACC_W-1:0] L_ONE  = ACC_W'(1 << FRAC);
  localparam logic signed [ACC_W-1:0] L_HALF = ACC_W'(1 << (FRAC-1));

  typedef enum logic [2:0] {
    S_IDLE, S_HMAC, S_HACT, S_OMAC, S_OACT
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_wr_err;
  logic [1:0]               r_mode;
  logic [IN_W-1:0]          r_in [N_IN];
  logic [IW-1:0]            r_i;
  logic [JW-1:0]            r_j;
  logic [AW-1:0]            r_ptr;
  logic signed [ACC_W-1:0]  r_acc;
  logic [W_W-1:0]           r_par [NPAR];
  logic signed [OUT_W-1:0]  r_h [N_HID];
  logic signed [OUT_W-1:0]  r_out;

  logic signed [OUT_W-1:0]  w_a;
  logic signed [W_W-1:0]    w_b;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_sum;
  logic [B_W-1:0]           w_bias;
  logic signed [OUT_W-1:0]  w_act;
  logic                     w_wr_ok;

  function automatic logic signed [OUT_W-1:0] f_act(
    input logic signed [ACC_W-1:0] a,
    input logic [1:0]              m
  );
    logic signed [ACC_W-1:0] x;
    x = a;
    unique case (1'b1)
      (m == 2'd0): x = a;
      (m == 2'd2): begin
        x = (a >>> 2) + L_HALF;
        if (x < 0) x = '0;
        else if (x > L_ONE) x = L_ONE;
      end
      default: x = (a < 0) ? '0 : a;
    endcase
    if (x > L_MAX) x = L_MAX;
    else if (x < L_MIN) x = L_MIN;
    return x[OUT_W-1:0];
  endfunction

  // r_ptr walks hidden weights then output weights in address order
  always_comb begin
    w_a = (r_state == S_OMAC) ? r_h[r_j]
                              : $signed(OUT_W'(r_in[r_i]));
    w_b = $signed(r_par[r_ptr]);
    w_prod = w_a * w_b;
    w_term = (r_state == S_OMAC) ? ACC_W'(w_prod >>> FRAC)
                                 : ACC_W'(w_prod);
    w_bias = (r_state == S_OACT)
      ? r_par[NPAR-1][B_W-1:0]
      : r_par[AW'(B_BASE) + AW'(r_j)][B_W-1:0];
    w_sum = r_acc + $signed(ACC_W'(w_bias) << FRAC);
    w_act = f_act(w_sum, r_mode);
    w_wr_ok = !r_busy
      && !(r_state == S_IDLE && bus.start)
      && (int'(bus.wr_addr) < NPAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      r_mode   <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_ptr    <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      for (int k = 0; k < N_IN; k++) r_in[k] <= '0;
      for (int k = 0; k < NPAR; k++) r_par[k] <= '0;
      for (int k = 0; k < N_HID; k++) r_h[k] <= '0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      if (bus.wr_en) begin
        if (w_wr_ok) r_par[bus.wr_addr] <= bus.wr_data;
        else r_wr_err <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode <= bus.act_mode;
            for (int k = 0; k < N_IN; k++)
              r_in[k] <= bus.in_vec[k*IN_W +: IN_W];
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_HMAC;
          end
        end
        S_HMAC: begin
          r_acc <= r_acc + w_term;
          r_ptr <= r_ptr + 1'b1;
          if (r_i == IW'(N_IN-1)) begin
            r_i     <= '0;
            r_state <= S_HACT;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_HACT: begin
          r_h[r_j] <= w_act;
          r_acc    <= '0;
          if (r_j == JW'(N_HID-1)) begin
            r_j     <= '0;
            r_state <= S_OMAC;
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= S_HMAC;
          end
        end
        S_OMAC: begin
          r_acc <= r_acc + w_term;
          r_ptr <= r_ptr + 1'b1;
          if (r_j == JW'(N_HID-1)) begin
            r_j     <= '0;
            r_state <= S_OACT;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_OACT: begin
          r_out   <= w_act;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.h_out = '0;
    for (int j = 0; j < N_HID; j++)
      bus.h_out[j*OUT_W +: OUT_W] = r_h[j];
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.wr_err = r_wr_err;
  assign bus.out_o  = r_out;
endmodule

// File: tb/tb_nn_seq_layer.sv
// Scoreboard bench for nn_seq_layer: integer reference model,
// directed test-plan cases plus randomized runs.
module tb_nn_seq_layer;
  localparam int N_IN   = 4;
  localparam int N_HID  = 3;
  localparam int IN_W   = 2;
  localparam int W_W    = 8;
  localparam int B_W    = 3;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 12;
  localparam int NPAR   = N_IN*N_HID + 2*N_HID + 1;
  localparam int AW     = $clog2(NPAR);
  localparam int V_BASE = N_IN*N_HID;
  localparam int B_BASE = V_BASE + N_HID;
  localparam int LAT    = N_HID*(N_IN+1) + N_HID + 1;

  typedef struct {
    logic [N_HID*OUT_W-1:0] hv;
    int o;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;
  exp_t sbq[$];
  logic [7:0] m_par [NPAR];

  nn_seq_layer_if #(
    .N_IN(N_IN), .N_HID(N_HID), .IN_W(IN_W),
    .W_W(W_W), .OUT_W(OUT_W)
  ) bus ();

  nn_seq_layer #(
    .N_IN(N_IN), .N_HID(N_HID), .IN_W(IN_W), .W_W(W_W),
    .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int hsl(input logic [N_HID*OUT_W-1:0] v, input int j);
    return int'($signed(v[j*OUT_W +: OUT_W]));
  endfunction

  function automatic int act(input int a, input logic [1:0] m);
    int t;
    if (m == 2'd2) begin
      t = (a >>> 2) + 64;
      if (t < 0) t = 0;
      if (t > 128) t = 128;
    end else if (m == 2'd0) begin
      t = a;
    end else begin
      t = (a < 0) ? 0 : a;
    end
    if (t > 2047) t = 2047;
    if (t < -2048) t = -2048;
    return t;
  endfunction

  function automatic exp_t model(input logic [1:0] m, input logic [7:0] iv);
    exp_t e;
    int acc;
    int h [N_HID];
    for (int j = 0; j < N_HID; j++) begin
      acc = int'(m_par[B_BASE+j] % 8) * 128;
      for (int i = 0; i < N_IN; i++)
        acc += int'(iv[i*IN_W +: IN_W]) * int'($signed(m_par[j*N_IN+i]));
      h[j] = act(acc, m);
      e.hv[j*OUT_W +: OUT_W] = h[j][OUT_W-1:0];
    end
    acc = int'(m_par[NPAR-1] % 8) * 128;
    for (int j = 0; j < N_HID; j++)
      acc += (h[j] * int'($signed(m_par[V_BASE+j]))) >>> 7;
    e.o = act(acc, m);
    e.cyc = 0;
    return e;
  endfunction

  // monitor: every done pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        n_done++;
        chk("done_expected", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          for (int j = 0; j < N_HID; j++)
            chk($sformatf("h%0d", j), hsl(bus.h_out, j), hsl(e.hv, j));
          chk("out_o", int'($signed(bus.out_o)), e.o);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", bus.busy, 0);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] d, input bit err);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk($sformatf("wr_err_a%0d", a), bus.wr_err, err);
    if (!err) m_par[a] = d;
  endtask

  task automatic set_all(input logic [7:0] wv, vv, bv, bov);
    for (int a = 0; a < NPAR; a++)
      wr(a, (a < V_BASE) ? wv : (a < B_BASE) ? vv : (a < NPAR-1) ? bv : bov, 0);
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] iv, input bit with_wr);
    exp_t e;
    e = model(m, iv);
    e.cyc = cyc + LAT + 1;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.act_mode = m;
    bus.in_vec = iv;
    if (with_wr) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = '0;
      bus.wr_data = 8'h11;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (with_wr) chk("wr_err_on_start", bus.wr_err, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_in_budget", int'(n < 60), 1);
    if (n >= 60) sbq.delete();
  endtask

  task automatic run(input logic [1:0] m, input logic [7:0] iv);
    issue(m, iv, 0);
    wait_idle();
  endtask

  task automatic chk_nom(input string tag, input int hx, input int ox);
    for (int j = 0; j < N_HID; j++)
      chk($sformatf("%s_h%0d", tag, j), hsl(bus.h_out, j), hx);
    chk($sformatf("%s_out", tag), int'($signed(bus.out_o)), ox);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] nom;
    int nd;
    nom = 8'h9E;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.act_mode = '0;
    bus.in_vec = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int a = 0; a < NPAR; a++) m_par[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_h_out", bus.h_out, 0);
    chk("rst_out_o", bus.out_o, 0);
    run(2'd2, nom);

    set_all(8'h40, 8'h40, 8'h01, 8'h01);
    run(2'd1, nom);
    chk_nom("relu_nom", 640, 1088);
    run(2'd2, nom);
    chk_nom("hsig_nom", 128, 128);

    set_all(8'h80, 8'h40, 8'h01, 8'h01);
    run(2'd1, nom);
    chk_nom("relu_neg", 0, 128);
    run(2'd0, nom);
    chk_nom("id_neg", -896, -1216);
    run(2'd3, nom);

    set_all(8'h7F, 8'h40, 8'h07, 8'h01);
    run(2'd0, 8'hFF);
    chk("sat_h0", hsl(bus.h_out, 0), 2047);

    // handshake: ignored start, rejected writes, unchanged weights
    set_all(8'h40, 8'h40, 8'h01, 8'h01);
    issue(2'd1, nom, 0);
    wr(0, 8'h11, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    chk_nom("busy_wr", 640, 1088);
    issue(2'd1, nom, 1);
    wait_idle();
    chk_nom("start_wr", 640, 1088);
    wr(21, 8'h55, 1);
    run(2'd1, nom);
    chk_nom("after_rej", 640, 1088);

    // back-to-back: second start in the done cycle
    issue(2'd1, nom, 0);
    for (int n = 0; n < 40 && !bus.done; n++) begin
      @(posedge clk); #1;
    end
    chk("b2b_done_seen", bus.done, 1);
    issue(2'd0, nom, 0);
    wait_idle();

    // reset asserted at edge 7 of a run
    nd = n_done;
    bus.start = 1'b1;
    bus.act_mode = 2'd1;
    bus.in_vec = nom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int a = 0; a < NPAR; a++) m_par[a] = '0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_h_out", bus.h_out, 0);
    chk("abort_out_o", bus.out_o, 0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", n_done, nd);
    run(2'd0, nom);
    chk("zero_out", int'($signed(bus.out_o)), 0);

    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < NPAR; a++) wr(a, 8'($urandom), 0);
      run(2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_seq_layer.md
# nn_seq_layer

Parametrised, time-multiplexed two-layer fixed-point neural network: N_IN inputs, N_HID hidden neurons and one output neuron, all sharing a single multiply-accumulate unit. It is the synthesizable successor to the four-input, three-hidden-neuron real-valued network. Weights and biases are loaded through a register-write port, and a start/done handshake runs one inference. The activation is selectable per run.

## Interface
- N_IN, 4, number of inputs
- N_HID, 3, number of hidden neurons
- IN_W, 2, input width, unsigned integer
- W_W, 8, weight width, signed Q1.(W_W-1); FRAC = W_W-1
- B_W, 3, bias width, unsigned integer
- ACC_W, 20, accumulator width, signed, FRAC fractional bits
- OUT_W, 12, activation output width, signed, FRAC fractional bits
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- act_mode  in  2  0 identity, 1 ReLU, 2 hard-sigmoid, 3 treated as ReLU; latched with start
- in_vec  in  N_IN*IN_W  input i at bits [i*IN_W +: IN_W]; latched with start
- wr_en  in  1  parameter write strobe
- wr_addr  in  $clog2(N_IN*N_HID+2*N_HID+1)  parameter address
- wr_data  in  W_W  weight, or bias in low B_W bits
- busy  out  1  inference in progress
- done  out  1  one-cycle pulse when results are valid
- wr_err  out  1  one-cycle pulse when a write is rejected
- h_out  out  N_HID*OUT_W  hidden activations; neuron j at [j*OUT_W +: OUT_W]
- out_o  out  OUT_W  output-neuron activation

## Operation
- Address map:
  - 0..N_IN*N_HID-1: hidden weight w[j][i], addr = j*N_IN+i.
  - Next N_HID addresses: output weights v[j].
  - Next N_HID addresses: hidden biases b[j].
  - Last address: output bias b_o.
- A write is rejected (no update, wr_err=1 for the next cycle) when busy=1, or on the start-accept edge itself, or when wr_addr is out of range.
- FSM states and transitions:
  - IDLE -> HMAC on start.
  - HMAC runs N_IN edges, then goes to HACT (1 edge).
  - HACT -> HMAC for the next neuron, or -> OMAC after neuron N_HID-1.
  - OMAC runs N_HID edges, then goes to OACT (1 edge).
  - OACT -> IDLE.
- Hidden neuron j:
  - acc = sum_i zext(in_i)*w[j][i] + (b[j] << FRAC). The product is already at FRAC fractional bits.
- Output neuron:
  - acc = sum_j ((h_j*v[j]) >>> FRAC) + (b_o << FRAC).
  - The shift is arithmetic and truncates toward -inf.
- Activation, applied to acc with the result saturated to the signed OUT_W range:
  - identity: saturate(acc).
  - ReLU: acc<0 -> 0, else saturate(acc).
  - hard-sigmoid: clamp((acc>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC).
- ACC_W must cover worst-case sums. This is checked by a parameter assertion, with no run-time overflow handling.
- h_out and out_o hold their values until the next run writes them. h_out[j] updates on its HACT edge.
- start while busy=1 is ignored, with no queueing.

## Timing
- Edge 0 is the edge sampling start=1 in IDLE. On it, in_vec and act_mode are latched, the accumulator is cleared, and busy goes to 1.
- OACT occurs on edge LAT = N_HID*(N_IN+1) + N_HID + 1, which is 19 for the defaults.
  - After that edge: done=1 and out_o is valid for one cycle, and busy=0.
- start may be reasserted in the cycle done=1. It is accepted on the next edge, giving back-to-back runs every LAT+1 cycles.
- Reset values: busy=0, done=0, wr_err=0, h_out=0, out_o=0. All weights and biases are cleared to 0 and the FSM goes to IDLE.
- Reset asserted mid-run aborts the run immediately with no done pulse.
- Parameter writes take effect on the edge after wr_en and are visible to the next run.

## Test plan
- ReLU nominal:
  - Stimulus: in=(2,3,1,2), all w=0x40 (0.5), all v=0x40, all biases=1.
  - Response: each h=640 (5.0), out_o=1088 (8.5), done exactly 19 edges after start.
- Negative weights:
  - Stimulus: all w=0x80 (-1.0), same inputs and biases, v=0x40.
  - ReLU response: h=0, out_o=128.
  - Identity response: h=-896, out_o=-1216.
- Saturation and hard-sigmoid:
  - Stimulus: in all 3, w=0x7F, b=7.
  - Identity response: h=2047.
  - Hard-sigmoid with the nominal setup: h=128, out_o=128.
- Handshake:
  - Stimulus: start pulsed during busy; a write issued during busy; wr_addr=21 while idle.
  - Response: the extra start is ignored; each rejected write gives a wr_err pulse; the weights are unchanged; the next run matches nominal.
- Back-to-back and reset:
  - Stimulus: start in the done cycle; then rst_n low at edge 7 of a run.
  - Response: the second run's done comes 20 cycles after the first run's done. After the reset: busy=0, outputs=0, no done, and a rerun with zero weights gives out_o=0.
